// File: rtl/onchip_memory_master_pkg.sv
// onchip_memory_master_pkg
//   Shared definitions for the on-chip memory initiator: the command FSM state
//   encoding and the all-lanes byte-enable constant.
package onchip_memory_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/avm_rd_fifo.sv
// avm_rd_fifo
//   Small synchronous FIFO holding read data returned by the memory until the
//   downstream consumer takes it.
//   Ports:
//     clk, clr_n              clock, asynchronous active-low clear
//     push, push_data         write side (no full check; the caller limits pushes by credit)
//     out_valid/out_ready     read-side handshake
//     out_data                head word; while empty it holds the last word popped
//     count                   current occupancy
//   FIFO_DEPTH must be a power of two and at least 2.
module avm_rd_fifo #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] last_q;
  logic              pop;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // Empty FIFO keeps presenting the most recently delivered word.
  assign out_data  = out_valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/onchip_memory_master.sv
// onchip_memory_master
//   Avalon-MM initiator for a 2^ADDR_W x DATA_W single-port on-chip memory
//   (read latency READ_LATENCY). Executes block commands: a write streams
//   wr_data words into consecutive addresses, a read streams memory words out
//   through a credit-managed FIFO so rd_ready backpressure never drops data.
//   Ports:
//     clk, reset_n                    clock, asynchronous active-low reset
//     cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_len   block command (len 0 = no-op)
//     wr_valid/wr_ready, wr_data      write-data stream
//     rd_valid/rd_ready, rd_data      read-data stream
//     done                            one-cycle pulse after command completion
//     busy                            command in progress
//     avm_*                           Avalon-MM initiator towards the memory's s1 port
module onchip_memory_master
  import onchip_memory_master_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 6,
  parameter int FIFO_DEPTH   = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_debugaccess,
  output logic              avm_clken,
  output logic              avm_reset_req,
  output logic              avm_freeze,
  input  logic [DATA_W-1:0] avm_readdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(READ_LATENCY + 1);

  state_e                state;
  logic [ADDR_W-1:0]     cur_addr;
  logic [LEN_W-1:0]      remaining;
  logic                  done_q;
  logic [READ_LATENCY:1] vld_pipe;   // one bit per outstanding read, aged each cycle
  logic [INF_W-1:0]      inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic                  wr_issue, rd_issue, rd_push, rd_pop, credit_ok, last_beat;

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= READ_LATENCY; i++) inflight = inflight + INF_W'(vld_pipe[i]);
  end

  // Reads already issued but not yet in the FIFO still own a slot, so the
  // FIFO can never overflow whatever rd_ready does.
  assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign wr_issue  = (state == WRITE) && wr_valid;
  assign rd_issue  = (state == READ) && credit_ok;
  assign rd_push   = vld_pipe[READ_LATENCY];
  assign rd_pop    = rd_valid && rd_ready;
  assign last_beat = (remaining == LEN_W'(1));

  // The done cycle keeps cmd_ready low so commands are always separated.
  assign cmd_ready = (state == IDLE) && !done_q;
  assign wr_ready  = (state == WRITE);
  assign done      = done_q;
  assign busy      = (state != IDLE) || done_q;

  assign avm_chipselect  = wr_issue || rd_issue;
  assign avm_write       = wr_issue;
  // The memory only honours writes when debugaccess is set.
  assign avm_debugaccess = wr_issue;
  assign avm_byteenable  = avm_chipselect ? BYTEEN_ALL : 4'h0;
  assign avm_address     = cur_addr;
  assign avm_writedata   = wr_issue ? wr_data : '0;
  assign avm_clken       = 1'b1;
  assign avm_reset_req   = 1'b0;
  assign avm_freeze      = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      done_q      <= 1'b0;
      vld_pipe[1] <= rd_issue;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len == '0) done_q <= 1'b1;
            else               state  <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_issue) begin
            cur_addr  <= cur_addr + ADDR_W'(1);   // wraps modulo memory depth
            remaining <= remaining - LEN_W'(1);
            if (last_beat) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Nothing left in flight and the final word leaves this cycle.
          if (inflight == '0 && fifo_count == CNT_W'(1) && rd_pop) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  avm_rd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) u_rd_fifo (
    .clk       (clk),
    .clr_n     (reset_n),
    .push      (rd_push),
    .push_data (avm_readdata),
    .out_valid (rd_valid),
    .out_ready (rd_ready),
    .out_data  (rd_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_onchip_memory_master.sv
// tb_onchip_memory_master
//   Bench with a behavioural memory slave and a reference word array; block
//   commands are driven with random data, stalls and backpressure.
module tb_onchip_memory_master;
  localparam int ADDR_W = 5, DATA_W = 32, LEN_W = 6, FIFO_DEPTH = 2, READ_LATENCY = 1;

  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready, rd_valid, rd_ready, done, busy;
  logic [ADDR_W-1:0] cmd_addr, avm_address;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data, rd_data, avm_writedata, avm_readdata;
  logic [3:0] avm_byteenable;
  logic avm_chipselect, avm_write, avm_debugaccess, avm_clken, avm_reset_req, avm_freeze;

  int total = 0, bad = 0;
  logic [31:0] slave_mem [32];
  logic [31:0] ref_mem [32];
  logic [31:0] slave_rd;
  logic init_mem = 1'b1;

  always #5 clk = ~clk;

  onchip_memory_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .FIFO_DEPTH(FIFO_DEPTH), .READ_LATENCY(READ_LATENCY)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .busy(busy), .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_debugaccess(avm_debugaccess), .avm_clken(avm_clken), .avm_reset_req(avm_reset_req),
    .avm_freeze(avm_freeze), .avm_readdata(avm_readdata));

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 ^ (i * 32'h00010203);
  endfunction

  // Memory slave: latency 1, write only with debugaccess, byte enables honoured.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32; i++) slave_mem[i] <= init_word(i);
    end else begin
      if (avm_chipselect && avm_write && avm_debugaccess)
        for (int b = 0; b < 4; b++)
          if (avm_byteenable[b]) slave_mem[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
      if (avm_chipselect && !avm_write) slave_rd <= slave_mem[avm_address];
    end
  end
  assign avm_readdata = slave_rd;

  task automatic test_reset();
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    total++;
    if ({wr_ready, rd_valid, done, busy, avm_chipselect, avm_write, avm_debugaccess} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000000",
        {wr_ready, rd_valid, done, busy, avm_chipselect, avm_write, avm_debugaccess});
    end
    total++;
    if ({avm_address, avm_writedata, rd_data} !== '0) begin
      bad++; $display("FAIL reset_data got addr=%h wd=%h rd=%h want=0", avm_address, avm_writedata, rd_data);
    end
    total++;
    if ({avm_clken, avm_reset_req, avm_freeze} !== 3'b100) begin
      bad++; $display("FAIL const_outs got=%b want=100", {avm_clken, avm_reset_req, avm_freeze});
    end
  endtask

  // Block write of n words base+i starting at a; stall_pct = chance of idle wr_valid.
  task automatic do_write(input int a, input int n, input logic [31:0] base, input int stall_pct, input string tag);
    int cyc = 0, acc = -1, sent = 0, dones = 0, last_cyc = -1, done_cyc = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'(a); cmd_len = 6'(n);
    #1;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; #1; end
    total++;
    if (!cmd_ready) begin bad++; $display("FAIL %s_accept got=timeout want=cmd_ready", tag); cmd_valid = 1'b0; return; end
    acc = cyc;
    for (cyc = acc + 1; cyc < acc + 400; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_valid = (sent < n) && ($urandom_range(99) >= stall_pct);
      wr_data = base + 32'(sent);
      #1;
      if (done_cyc < 0) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy cyc=%0d got=%b want=1", tag, cyc, busy); end
      end
      if (done === 1'b1) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
      if (sent < n) begin
        total++;
        if (avm_chipselect !== wr_valid) begin
          bad++; $display("FAIL %s_cs_gate cyc=%0d got=%b want=%b", tag, cyc, avm_chipselect, wr_valid);
        end
        if (wr_valid && wr_ready) begin
          total++;
          if ({avm_write, avm_debugaccess, avm_byteenable, avm_address, avm_writedata} !==
              {1'b1, 1'b1, 4'hF, 5'(a + sent), base + 32'(sent)}) begin
            bad++; $display("FAIL %s_beat%0d got we=%b dbg=%b be=%h addr=%0d wd=%h want 1 1 f %0d %h", tag, sent,
              avm_write, avm_debugaccess, avm_byteenable, avm_address, avm_writedata, (a + sent) % 32, base + 32'(sent));
          end
          ref_mem[(a + sent) % 32] = base + 32'(sent);
          sent++;
          if (sent == n) last_cyc = cyc;
        end
      end else begin
        total++;
        if (avm_chipselect !== 1'b0) begin bad++; $display("FAIL %s_extra_cs cyc=%0d got=%b want=0", tag, cyc, avm_chipselect); end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    wr_valid = 1'b0;
    total++;
    if (sent != n) begin bad++; $display("FAIL %s_sent got=%0d want=%0d", tag, sent, n); end
    total++;
    if (dones != 1 || done_cyc != ((n == 0) ? acc + 1 : last_cyc + 1)) begin
      bad++; $display("FAIL %s_done got count=%0d at=%0d want count=1 at=%0d", tag, dones, done_cyc,
        (n == 0) ? acc + 1 : last_cyc + 1);
    end
  endtask

  // Block read of n words from a. mode 0: rd_ready held, 1: 1 on / 3 off, 2: random.
  task automatic do_read(input int a, input int n, input int mode, input string tag);
    int cyc = 0, acc = -1, issued = 0, got = 0, dones = 0, done_cyc = -1, last_pop = -1;
    int first_iss = -1, first_vld = -1;
    logic [31:0] last_word = '0, want;
    bit have_last = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'(a); cmd_len = 6'(n);
    #1;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; #1; end
    total++;
    if (!cmd_ready) begin bad++; $display("FAIL %s_accept got=timeout want=cmd_ready", tag); cmd_valid = 1'b0; return; end
    acc = cyc;
    for (cyc = acc + 1; cyc < acc + 600; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      case (mode)
        0: rd_ready = 1'b1;
        1: rd_ready = ((cyc - acc) % 4 == 1);
        default: rd_ready = 1'($urandom_range(1));
      endcase
      #1;
      if (done === 1'b1) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
      if (avm_chipselect === 1'b1) begin
        total++;
        if (avm_write !== 1'b0 || avm_byteenable !== 4'hF || issued >= n || avm_address !== 5'(a + issued)) begin
          bad++; $display("FAIL %s_issue%0d got we=%b be=%h addr=%0d want 0 f %0d (n=%0d)", tag, issued,
            avm_write, avm_byteenable, avm_address, (a + issued) % 32, n);
        end
        issued++;
        if (first_iss < 0) first_iss = cyc;
      end
      total++;
      if (issued - got > FIFO_DEPTH) begin
        bad++; $display("FAIL %s_credit cyc=%0d got outstanding=%0d want<=%0d", tag, cyc, issued - got, FIFO_DEPTH);
      end
      if (rd_valid === 1'b1 && first_vld < 0) first_vld = cyc;
      if (rd_valid === 1'b1 && rd_ready) begin
        want = ref_mem[(a + got) % 32];
        total++;
        if (got >= n || rd_data !== want) begin
          bad++; $display("FAIL %s_word%0d got=%h want=%h (n=%0d)", tag, got, rd_data, want, n);
        end
        got++; last_word = want; have_last = 1; last_pop = cyc;
      end else if (rd_valid !== 1'b1 && have_last) begin
        total++;
        if (rd_data !== last_word) begin bad++; $display("FAIL %s_hold cyc=%0d got=%h want=%h", tag, cyc, rd_data, last_word); end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    rd_ready = 1'b0;
    total++;
    if (got != n || issued != n) begin bad++; $display("FAIL %s_count got rd=%0d iss=%0d want=%0d", tag, got, issued, n); end
    total++;
    if (dones != 1 || done_cyc != ((n == 0) ? acc + 1 : last_pop + 1)) begin
      bad++; $display("FAIL %s_done got count=%0d at=%0d want count=1 at=%0d", tag, dones, done_cyc,
        (n == 0) ? acc + 1 : last_pop + 1);
    end
    if (mode == 0 && n > 0) begin
      total++;
      if (first_vld != first_iss + READ_LATENCY + 1) begin
        bad++; $display("FAIL %s_latency got=%0d want=%0d", tag, first_vld - first_iss, READ_LATENCY + 1);
      end
    end
  endtask

  task automatic test_mem_image(input string tag);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (slave_mem[i] !== ref_mem[i]) begin bad++; $display("FAIL %s_mem[%0d] got=%h want=%h", tag, i, slave_mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_basic();
    do_write(2, 4, 32'hA0, 0, "basic_wr");
    do_read(2, 4, 0, "basic_rd");
    test_mem_image("basic");
  endtask

  task automatic test_wrap();
    do_write(30, 3, $urandom, 0, "wrap_wr");
    do_read(30, 3, 0, "wrap_rd");
    test_mem_image("wrap");
  endtask

  task automatic test_backpressure();
    do_write(8, 8, $urandom, 0, "bp_wr");
    do_read(8, 8, 1, "bp_rd");
  endtask

  task automatic test_zero_len();
    do_read(5, 0, 0, "zero_rd");
    do_write(5, 0, 32'h0, 0, "zero_wr");
  endtask

  task automatic test_write_stalls();
    do_write(12, 10, $urandom, 50, "stall_wr");
    do_read(12, 10, 2, "stall_rd");
    do_write(20, 40, $urandom, 30, "long_wr");
    do_read(20, 40, 2, "long_rd");
    test_mem_image("stall");
  endtask

  task automatic test_reset_mid();
    int issued = 0, cyc = 0;
    @(negedge clk);
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd0; cmd_len = 6'd8;
    #1;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; #1; end
    while (issued < 2 && cyc < 100) begin
      @(negedge clk); cyc++; cmd_valid = 1'b0; #1;
      if (avm_chipselect === 1'b1) issued++;
    end
    total++;
    if (issued != 2) begin bad++; $display("FAIL rstmid_issue got=%0d want=2", issued); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, wr_ready, rd_valid, done, busy, avm_chipselect, avm_write, avm_debugaccess} !== 8'b10000000) begin
      bad++; $display("FAIL rstmid_ctrl got=%b want=10000000",
        {cmd_ready, wr_ready, rd_valid, done, busy, avm_chipselect, avm_write, avm_debugaccess});
    end
    total++;
    if ({avm_address, avm_writedata, rd_data} !== '0) begin
      bad++; $display("FAIL rstmid_data got addr=%h wd=%h rd=%h want=0", avm_address, avm_writedata, rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) reset_n = 1'b1;
      #1;
      total++;
      if (done !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got done=%b rdv=%b want 0 0", done, rd_valid); end
    end
    do_read(0, 4, 0, "after_rst_rd");
    do_write(31, 2, $urandom, 20, "after_rst_wr");
    test_mem_image("after_rst");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    reset_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_write_stalls();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
